// File: rtl/avalon_blink_led_slave_if.sv
// Avalon-MM register bus between the Nios II data master and the blink LED slave.
interface avalon_blink_led_slave_if;
  logic        chipselect;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;

  modport master (
    output chipselect, address, write, writedata, read,
    input  readdata
  );

  modport slave (
    input  chipselect, address, write, writedata, read,
    output readdata
  );
endinterface

// File: rtl/avalon_blink_led_slave.sv
// Avalon-MM slave blinking two LEDs from a programmable half-period counter,
// with switch readback through a 2-FF synchronizer and a wrapping toggle count.
module avalon_blink_led_slave #(
  parameter int unsigned DEFAULT_PERIOD = 25000000,
  parameter int unsigned SW_WIDTH       = 8
) (
  input  logic                clk,
  input  logic                reset,
  avalon_blink_led_slave_if.slave bus,
  input  logic [SW_WIDTH-1:0] sw,
  output logic [1:0]          led
);

  logic [1:0]          ctrl_q,     ctrl_d;
  logic [31:0]         period_q,   period_d;
  logic [31:0]         cnt_q,      cnt_d;
  logic                phase_q,    phase_d;
  logic [15:0]         toggles_q,  toggles_d;
  logic [SW_WIDTH-1:0] sw_meta_q,  sw_meta_d;
  logic [SW_WIDTH-1:0] sw_sync_q,  sw_sync_d;
  logic [31:0]         readdata_q, readdata_d;
  logic [1:0]          led_q,      led_d;

  logic        wr_en, rd_en, period_wr, toggles_clr, terminal, wrap;
  logic [31:0] rd_mux;

  always_comb begin
    wr_en       = bus.chipselect & bus.write;
    rd_en       = bus.chipselect & bus.read;
    period_wr   = wr_en && (bus.address == 2'd1);
    toggles_clr = wr_en && (bus.address == 2'd3);
    terminal    = ctrl_q[0] && (cnt_q == period_q - 32'd1);
    // A PERIOD write in the terminal cycle suppresses the toggle.
    wrap        = terminal && !period_wr;

    ctrl_d    = ctrl_q;
    period_d  = period_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    toggles_d = toggles_q;

    if (wr_en && bus.address == 2'd0) ctrl_d = bus.writedata[1:0];
    if (period_wr) period_d = (bus.writedata == 32'd0) ? 32'd1 : bus.writedata;

    if (period_wr || !ctrl_q[0] || wrap) cnt_d = 32'd0;
    else                                 cnt_d = cnt_q + 32'd1;

    if (wrap) phase_d = ~phase_q;

    if (toggles_clr) toggles_d = 16'd0;
    else if (wrap)   toggles_d = toggles_q + 16'd1;

    // Readback uses pre-write register values so read+write returns old data.
    rd_mux = 32'd0;
    case (bus.address)
      2'd0: rd_mux = {30'd0, ctrl_q};
      2'd1: rd_mux = period_q;
      2'd2: rd_mux = 32'(sw_sync_q);
      2'd3: rd_mux = {16'd0, toggles_q};
      default: rd_mux = 32'd0;
    endcase
    readdata_d = rd_en ? rd_mux : 32'd0;

    sw_meta_d = sw;
    sw_sync_d = sw_meta_q;
    led_d     = {(ctrl_q[1] ? ~phase_q : phase_q), phase_q};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_q     <= 2'd0;
      period_q   <= 32'(DEFAULT_PERIOD);
      cnt_q      <= 32'd0;
      phase_q    <= 1'b0;
      toggles_q  <= 16'd0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      readdata_q <= 32'd0;
      led_q      <= 2'b00;
    end else begin
      ctrl_q     <= ctrl_d;
      period_q   <= period_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      toggles_q  <= toggles_d;
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
      readdata_q <= readdata_d;
      led_q      <= led_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign led          = led_q;

endmodule

// File: doc/avalon_blink_led_slave.md
Name: avalon_blink_led_slave

Overview:
- Custom Avalon-MM slave peripheral that the Nios II master drives to blink LEDs.
- The master programs the enable, mode and half-period registers, reads back the synchronized switches, and reads a toggle counter.
- The block is the responder end of the Nios data bus. It is instantiated inside the Qsys system, and its LED and switch conduits are exported to the board top level.

Parameters:
- DEFAULT_PERIOD, 25000000, reset value of the PERIOD register in clk cycles (0.5 s at 50 MHz).
- SW_WIDTH, 8, width of the switch input.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  synchronous, active-low reset (0 = reset).
- chipselect  input  1  Avalon slave select.
- address  input  2  word address of the register.
- write  input  1  write strobe, valid with chipselect.
- writedata  input  32  write data.
- read  input  1  read strobe, valid with chipselect.
- readdata  output  32  read data, 1-cycle read latency.
- sw  input  SW_WIDTH  asynchronous board switches.
- led  output  2  LED drive.

Behaviour:
- Clocking and reset:
  - All state updates on the rising edge of clk.
  - reset=0 sampled at an edge forces: CTRL=0, PERIOD=DEFAULT_PERIOD, cnt=0, phase=0, toggles=0, sw sync flops=0, readdata=0, led=2'b00.
  - Reset mid-count abandons the count; there is no partial state.
- Register map (word address):
  - 0 CTRL, R/W. bit0 EN, bit1 ALT. Other bits read as 0.
  - 1 PERIOD, R/W, 32-bit half-period in cycles. A write of 0 stores 1.
  - 2 SWITCH, RO. Returns {zeros, sw_sync}. Writes are ignored.
  - 3 TOGGLES, R/W1-any, 16-bit wrapping count of phase toggles. A write of any value clears it to 0. Reads return {16'b0, toggles}.
- Bus handshake:
  - Write takes effect at the edge where chipselect and write are both 1. There are no wait states.
  - Read: when chipselect and read are both 1 at edge N, readdata holds the addressed value at edge N+1. Otherwise readdata returns to 0 at the next edge.
  - Reads have no side effects.
  - read and write asserted together: the write is performed and readdata returns the pre-write value.
- Switch synchronizer:
  - 2-FF synchronizer on sw.
  - The SWITCH read reflects sw 2-3 cycles after an input change.
- Blink counter, enabled (EN=1):
  - cnt increments each cycle.
  - When cnt == PERIOD-1: cnt wraps to 0, phase inverts, toggles increments (mod 2^16).
- Blink counter, disabled (EN=0):
  - cnt is held at 0 and phase freezes at its last value.
  - Re-enabling starts a full fresh period.
- PERIOD write:
  - Loads the new value and clears cnt to 0 in the same cycle.
  - phase is unchanged.
  - If cnt had reached the old terminal value in that cycle, the write wins: no toggle occurs.
  - Writing a PERIOD smaller than the current cnt is safe because cnt is cleared.
- TOGGLES write coinciding with a wrap: the clear wins and toggles=0.
- Output mapping (registered):
  - led[0] = phase.
  - led[1] = ALT ? ~phase : phase.
  - led changes one cycle after the phase/CTRL update, so led is glitch-free.
- Address decode: unused CTRL bits and any undecoded state read as 0.

Test Plan:
- Reset:
  - Hold reset=0 for 3 cycles, then release.
  - Expect led=00 and readdata=0.
  - Read addr1 returns 25000000; read addr0 returns 0; read addr3 returns 0.
- Blinking:
  - Write PERIOD=4, then CTRL=1.
  - Expect phase toggling every 4 cycles: led[0] pattern 0000 1111 0000.
  - After 3 toggles, read addr3 returns 3.
- ALT mode and PERIOD clamp:
  - Write CTRL=3 and PERIOD=0.
  - Read addr1 returns 1.
  - led alternates 01/10 every cycle.
- Switch readback:
  - Set sw=8'hA5.
  - A read issued 3 cycles later returns 32'h000000A5 one cycle after the read strobe.
- Collisions:
  - With PERIOD=4, write PERIOD=8 on the terminal cycle: no toggle, and the next toggle comes 8 cycles later.
  - Write addr3 on a wrap cycle: read addr3 returns 0.
- Disable and reset mid-run:
  - Clear EN mid-period: led freezes.
  - Re-enable: the next toggle comes after exactly PERIOD cycles.
  - Assert reset mid-count: all registers return to reset values at the next edge.
